uart_tx_arbiter: RTL and testbench

- Shares one byte-wide UART transmitter among N_REQ requesters.
- Round-robin arbitration with an optional per-owner burst, so a requester can send short multi-byte messages unbroken.
- Sequences the transmitter through a start/busy handshake and inserts a configurable idle gap between frames.
- Sits between application producers (display/debug sources) and the UART transmit engine.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and transmitter frame constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle seen by the UART transmit arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]           req;
  logic [DATA_BITS*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]           ack;
  logic [DATA_BITS-1:0]       tx_byte;
  logic                       tx_start;
  logic                       tx_busy;
  logic [$clog2(N_REQ)-1:0]   owner;
  logic                       active;
  logic                       err_timeout;

  modport master (
    input  req, req_data, tx_busy,
    output ack, tx_byte, tx_start, owner, active, err_timeout
  );

  modport slave (
    output req, req_data, tx_busy,
    input  ack, tx_byte, tx_start, owner, active, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping to i_last itself.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_last,
  output logic [$clog2(N_REQ)-1:0] o_winner,
  output logic                     o_valid
);
  localparam int IW = $clog2(N_REQ);

  always_comb begin : pick
    logic [IW-1:0] w_idx;
    o_winner = '0;
    o_valid  = |i_req;
    w_idx    = '0;
    // Scan farthest-first so the nearest set request after i_last overwrites the rest.
    for (int i = N_REQ; i >= 1; i--) begin
      w_idx = IW'((int'(i_last) + i) % N_REQ);
      if (i_req[w_idx]) o_winner = w_idx;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter, with per-owner bursts and an idle gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int MAX_BURST     = 4,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst,
  uart_tx_arbiter_if.master  bus
);
  localparam int OW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam int TW = $clog2(START_TIMEOUT) + 1;

  state_t               r_state, w_state_next;
  logic [OW-1:0]        r_owner;
  logic [DATA_BITS-1:0] r_tx_byte;
  logic [BW-1:0]        r_burst;
  logic [GW-1:0]        r_gap;
  logic [TW-1:0]        r_to_cnt;
  logic                 r_err;

  logic [OW-1:0]        w_pick;
  logic                 w_pick_valid;
  logic                 w_grant;
  logic [OW-1:0]        w_grant_idx;
  logic [BW-1:0]        w_burst_next;
  logic                 w_gap_done;
  logic                 w_same_ok;
  logic                 w_to_hit;
  logic [DATA_BITS-1:0] w_bytes [N_REQ];
  logic [N_REQ-1:0]     w_ack;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign w_bytes[gi] = bus.req_data[gi*DATA_BITS +: DATA_BITS];
    assign w_ack[gi]   = (r_state == START) && (r_owner == OW'(gi));
  end

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .i_req    (bus.req),
    .i_last   (r_owner),
    .o_winner (w_pick),
    .o_valid  (w_pick_valid)
  );

  // A zero gap still spends one cycle in GAP because the counter loads 0.
  assign w_gap_done = (r_gap <= GW'(1));
  assign w_same_ok  = bus.req[r_owner] && (r_burst < BW'(MAX_BURST - 1));
  assign w_to_hit   = ((r_to_cnt + TW'(1)) == TW'(START_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_idx  = w_pick;
    w_burst_next = '0;
    case (r_state)
      IDLE: begin
        if (!bus.tx_busy && w_pick_valid) begin
          w_grant      = 1'b1;
          w_state_next = START;
        end
      end
      START: w_state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy)   w_state_next = WAIT_DONE;
        else if (w_to_hit) w_state_next = IDLE;
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) w_state_next = GAP;
      end
      GAP: begin
        if (w_gap_done) begin
          if (w_same_ok) begin
            w_grant      = 1'b1;
            w_grant_idx  = r_owner;
            w_burst_next = r_burst + BW'(1);
            w_state_next = START;
          end else if (w_pick_valid) begin
            w_grant      = 1'b1;
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ack         = w_ack;
    bus.tx_start    = (r_state == START);
    bus.active      = (r_state != IDLE);
    bus.tx_byte     = r_tx_byte;
    bus.owner       = r_owner;
    bus.err_timeout = r_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner   <= OW'(N_REQ - 1);
      r_tx_byte <= '0;
      r_burst   <= '0;
      r_gap     <= '0;
      r_to_cnt  <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner   <= w_grant_idx;
        r_tx_byte <= w_bytes[w_grant_idx];
        r_burst   <= w_burst_next;
      end
      if (r_state == START)
        r_to_cnt <= '0;
      else if (r_state == WAIT_BUSY && !bus.tx_busy && !w_to_hit)
        r_to_cnt <= r_to_cnt + TW'(1);
      if (r_state == WAIT_DONE && !bus.tx_busy)
        r_gap <= GW'(GAP_CYCLES);
      else if (r_state == GAP && !w_gap_done)
        r_gap <= r_gap - GW'(1);
      if (r_state == WAIT_BUSY && !bus.tx_busy && w_to_hit)
        r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one default instance and one single-byte-burst instance.
module tb_uart_tx_arbiter;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   n;

  uart_tx_arbiter_if #(.N_REQ(4)) bus_a ();
  uart_tx_arbiter_if #(.N_REQ(4)) bus_b ();

  uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(4), .GAP_CYCLES(16), .START_TIMEOUT(64)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(1), .GAP_CYCLES(16), .START_TIMEOUT(64)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Waits for tx_start, checks the grant, then plays a 6-cycle transmitter frame.
  task automatic frame(input bit sel, input int own, input logic [7:0] byt, input int exp_lat);
    int lat = 0;
    while ((sel ? bus_b.tx_start : bus_a.tx_start) !== 1'b1 && lat < 300) begin
      tick(1);
      lat++;
    end
    chk("frame_start", 32'(sel ? bus_b.tx_start : bus_a.tx_start), 32'd1);
    if (exp_lat >= 0) chk("gap_latency", 32'(lat), 32'(exp_lat));
    chk("frame_ack", 32'(sel ? bus_b.ack : bus_a.ack), 32'(1) << own);
    chk("frame_owner", 32'(sel ? bus_b.owner : bus_a.owner), 32'(own));
    chk("frame_byte", 32'(sel ? bus_b.tx_byte : bus_a.tx_byte), 32'(byt));
    $display("frame dut=%0d owner=%0d byte=%02h wait=%0d",
             sel, own, byt, lat);
    tick(1);
    if (sel) bus_b.tx_busy = 1'b1; else bus_a.tx_busy = 1'b1;
    tick(6);
    if (sel) bus_b.tx_busy = 1'b0; else bus_a.tx_busy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_a.req = '0; bus_a.req_data = '0; bus_a.tx_busy = 1'b0;
    bus_b.req = '0; bus_b.req_data = '0; bus_b.tx_busy = 1'b0;
    tick(2);
    rst = 1'b0;

    chk("rst_ack", 32'(bus_a.ack), 32'd0);
    chk("rst_start", 32'(bus_a.tx_start), 32'd0);
    chk("rst_byte", 32'(bus_a.tx_byte), 32'd0);
    chk("rst_owner", 32'(bus_a.owner), 32'd3);
    chk("rst_active", 32'(bus_a.active), 32'd0);
    chk("rst_err", 32'(bus_a.err_timeout), 32'd0);
    $display("reset checked");

    // Single request with a 100-cycle transmitter frame.
    bus_a.req_data = 32'h0000_4100;
    bus_a.req = 4'b0010;
    tick(1);
    chk("t1_ack", 32'(bus_a.ack), 32'h2);
    chk("t1_start", 32'(bus_a.tx_start), 32'd1);
    chk("t1_byte", 32'(bus_a.tx_byte), 32'h41);
    chk("t1_owner", 32'(bus_a.owner), 32'd1);
    bus_a.req = '0;
    tick(1);
    chk("t1_start_pulse", 32'(bus_a.tx_start), 32'd0);
    chk("t1_ack_pulse", 32'(bus_a.ack), 32'd0);
    bus_a.tx_busy = 1'b1;
    tick(50);
    bus_a.req_data = 32'h0000_FF00;
    tick(50);
    chk("t1_byte_hold", 32'(bus_a.tx_byte), 32'h41);
    bus_a.tx_busy = 1'b0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      n += int'(bus_a.active);
    end
    chk("t1_gap_cycles", 32'(n), 32'd16);
    tick(1);
    chk("t1_idle", 32'(bus_a.active), 32'd0);
    $display("single request done");

    // Burst from requester 2, interrupted by requester 0 after four bytes.
    bus_a.req_data = 32'h00A0_0000;
    bus_a.req = 4'b0100;
    frame(1'b0, 2, 8'hA0, 1);
    bus_a.req_data[23:16] = 8'hA1;
    frame(1'b0, 2, 8'hA1, 17);
    bus_a.req_data[23:16] = 8'hA2;
    frame(1'b0, 2, 8'hA2, 17);
    bus_a.req_data[23:16] = 8'hA3;
    bus_a.req_data[7:0]   = 8'hB0;
    bus_a.req = 4'b0101;
    frame(1'b0, 2, 8'hA3, 17);
    bus_a.req_data[23:16] = 8'hA4;
    frame(1'b0, 0, 8'hB0, 17);
    bus_a.req = 4'b0100;
    frame(1'b0, 2, 8'hA4, 17);
    bus_a.req_data[23:16] = 8'hA5;
    frame(1'b0, 2, 8'hA5, 17);
    bus_a.req = '0;
    tick(17);
    chk("burst_idle", 32'(bus_a.active), 32'd0);

    // Lone requester past its burst limit wraps back to itself.
    bus_a.req = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      bus_a.req_data[31:24] = 8'hC0 + 8'(i);
      frame(1'b0, 3, 8'hC0 + 8'(i), (i == 0) ? 1 : 17);
    end
    bus_a.req = '0;
    tick(17);

    // Transmitter never answers: sticky timeout exactly 64 cycles after tx_start.
    bus_a.req_data[15:8] = 8'h5A;
    bus_a.req = 4'b0010;
    tick(1);
    chk("to_start", 32'(bus_a.tx_start), 32'd1);
    chk("to_byte", 32'(bus_a.tx_byte), 32'h5A);
    bus_a.req = '0;
    n = 0;
    for (int i = 1; i < 64; i++) begin
      tick(1);
      n += int'(bus_a.err_timeout);
    end
    chk("to_early", 32'(n), 32'd0);
    tick(1);
    chk("to_err", 32'(bus_a.err_timeout), 32'd1);
    chk("to_idle", 32'(bus_a.active), 32'd0);
    bus_a.req_data[31:24] = 8'h77;
    bus_a.req = 4'b1000;
    frame(1'b0, 3, 8'h77, 1);
    bus_a.req = '0;
    chk("to_sticky", 32'(bus_a.err_timeout), 32'd1);
    tick(17);

    // Transmitter busy while idle holds arbitration off.
    bus_a.tx_busy = 1'b1;
    bus_a.req_data[23:16] = 8'h3C;
    bus_a.req = 4'b0100;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n += int'(bus_a.ack != 4'b0000) + int'(bus_a.active);
    end
    chk("busy_hold", 32'(n), 32'd0);
    bus_a.tx_busy = 1'b0;
    frame(1'b0, 2, 8'h3C, 1);
    bus_a.req = '0;
    tick(17);

    // Asynchronous reset in the middle of a frame.
    bus_a.req_data[15:8] = 8'h99;
    bus_a.req = 4'b0010;
    tick(1);
    bus_a.req = '0;
    tick(1);
    bus_a.tx_busy = 1'b1;
    tick(3);
    chk("ar_pre_active", 32'(bus_a.active), 32'd1);
    bus_a.req = 4'b1001;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_active", 32'(bus_a.active), 32'd0);
    chk("ar_byte", 32'(bus_a.tx_byte), 32'd0);
    chk("ar_owner", 32'(bus_a.owner), 32'd3);
    chk("ar_err", 32'(bus_a.err_timeout), 32'd0);
    chk("ar_start", 32'(bus_a.tx_start), 32'd0);
    bus_a.tx_busy = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("ar_first_ack", 32'(bus_a.ack), 32'h1);
    chk("ar_first_owner", 32'(bus_a.owner), 32'd0);
    $display("async reset done");
    bus_a.req = 4'b1000;
    tick(1);
    bus_a.tx_busy = 1'b1;
    tick(3);
    bus_a.tx_busy = 1'b0;
    frame(1'b0, 3, 8'h77, 17);
    bus_a.req = '0;

    // Full contention with single-byte bursts.
    bus_b.req_data = 32'hD3D2_D1D0;
    bus_b.req = 4'b1111;
    for (int g = 0; g < 5; g++)
      frame(1'b1, g % 4, 8'hD0 + 8'(g % 4), (g == 0) ? 1 : 17);
    bus_b.req = '0;
    tick(17);
    chk("cont_idle", 32'(bus_b.active), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
